uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx instance among NUM_REQ byte producers, such as button handlers and status reporters.
- Each requester offers one byte on a valid/ready handshake.
- The arbiter latches the winner's byte, drives tx_data and issues a one-cycle tx_start.
- It then tracks tx_busy until the frame completes.
- It sits between the requesters and uart_tx inside the uart top, alongside baud_tick_gen.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       done,
  output logic                       err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d, done_q, done_d, err_q, err_d, xfer;

  // Scan downward so the nearest valid requester after the pointer is the last one written
  always_comb begin
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[IW'((int'(ptr_q) + k) % NUM_REQ)]) win = IW'((int'(ptr_q) + k) % NUM_REQ);
  end

  assign req_ready   = (state_q == IDLE && !tx_busy && |req_valid) ? NUM_REQ'(1) << win : '0;
  assign xfer        = |(req_valid & req_ready);
  assign arb_busy    = state_q != IDLE;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign done        = done_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        data_d  = req_data[{win, 3'b000} +: 8];
        grant_d = win;
        ptr_d   = win;
        start_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      else begin
        cnt_d   = cnt_q + 1'b1;
        err_d   = cnt_d == TW'(BUSY_TIMEOUT - 1);
        state_d = err_d ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: if (!tx_busy) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, corner sequences and random traffic against a timeline model
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, arb_busy, done, err_timeout;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int busy_from = -1, busy_to = -2, busy_len = 20;
  bit uart_en = 1'b1, force_busy = 1'b0;
  int last_done = -100;

  typedef struct {
    logic [N-1:0] valid;
    int           grant;
    logic [7:0]   data;
    bit           gap;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic upd_busy();
    tx_busy = force_busy || (cyc >= busy_from && cyc <= busy_to);
  endtask

  // uart model: busy rises 2 cycles after tx_start and stays up busy_len cycles
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start && uart_en) begin
      busy_from = cyc + 2;
      busy_to   = cyc + 1 + busy_len;
    end
    if (done) last_done = cyc;
    upd_busy();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    busy_to = -2;
    upd_busy();
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_frame(input logic [N-1:0] v, input int g, input logic [7:0] d,
                           input bit gap, input string nm);
    int w, s, n_start, n_bad;
    w = 0; n_start = 0; n_bad = 0;
    req_valid = v;
    #1;
    while (req_ready == '0 && w < 100) begin tick(); w++; end
    chk({nm, " ready"}, 32'(req_ready), 32'(1) << g);
    tick();
    chk({nm, " ready drop"}, 32'(req_ready), 0);
    req_valid = '0;
    #1;
    s = cyc;
    chk({nm, " start"}, 32'(tx_start), 1);
    chk({nm, " data"}, 32'(tx_data), 32'(d));
    chk({nm, " grant"}, 32'(grant_id), g);
    if (gap) chk({nm, " done-to-start"}, s - last_done, 1);
    w = 0;
    while (!done && w < 100) begin
      tick(); w++;
      n_start += int'(tx_start);
      n_bad += int'(tx_data !== d);
    end
    chk({nm, " done"}, 32'(done), 1);
    if (uart_en) chk({nm, " done latency"}, cyc - s, busy_len + 3);
    chk({nm, " extra starts"}, n_start, 0);
    chk({nm, " data stable"}, n_bad, 0);
    chk({nm, " idle"}, 32'(arb_busy), 0);
    chk({nm, " no err"}, 32'(err_timeout), 0);
  endtask

  initial begin
    logic [N-1:0] pend, er;
    logic [7:0]   pdata[N];
    logic [7:0]   eb;
    int s, w, free_at, mptr, es, ed, ee, eg, xw;

    tbl[0]  = '{4'b1111, 0, 8'h41, 1'b0};
    tbl[1]  = '{4'b1111, 1, 8'h42, 1'b1};
    tbl[2]  = '{4'b1111, 2, 8'h43, 1'b1};
    tbl[3]  = '{4'b1111, 3, 8'h44, 1'b1};
    tbl[4]  = '{4'b1111, 0, 8'h41, 1'b1};
    tbl[5]  = '{4'b0100, 2, 8'h43, 1'b1};
    tbl[6]  = '{4'b0100, 2, 8'h43, 1'b1};
    tbl[7]  = '{4'b0100, 2, 8'h43, 1'b1};
    tbl[8]  = '{4'b1001, 3, 8'h44, 1'b1};
    tbl[9]  = '{4'b1001, 0, 8'h41, 1'b1};
    tbl[10] = '{4'b0110, 1, 8'h42, 1'b1};
    tbl[11] = '{4'b1010, 3, 8'h44, 1'b1};
    tbl[12] = '{4'b0011, 0, 8'h41, 1'b1};

    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    do_reset();
    chk("rst tx_start", 32'(tx_start), 0);
    chk("rst tx_data", 32'(tx_data), 0);
    chk("rst grant", 32'(grant_id), 0);
    chk("rst arb_busy", 32'(arb_busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err_timeout), 0);
    chk("rst ready", 32'(req_ready), 0);

    req_data[7:0] = 8'h30;
    run_frame(4'b0001, 0, 8'h30, 1'b0, "single");

    do_reset();
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    for (int i = 0; i < 13; i++)
      run_frame(tbl[i].valid, tbl[i].grant, tbl[i].data, tbl[i].gap, $sformatf("row%0d", i));

    // uart never answers: abort after the timeout, then serve the queued request
    uart_en = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("to ready", 32'(req_ready), 4'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("to start", 32'(tx_start), 1);
    s = cyc; w = 0;
    while (!err_timeout && w < 40) begin tick(); w++; end
    chk("to latency", cyc - s, 16);
    chk("to err", 32'(err_timeout), 1);
    chk("to done excl", 32'(done), 0);
    chk("to idle", 32'(arb_busy), 0);
    chk("to next ready", 32'(req_ready), 4'b1000);
    uart_en = 1'b1;
    run_frame(4'b1000, 3, 8'h44, 1'b0, "to_next");

    force_busy = 1'b1;
    upd_busy();
    req_valid = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("held busy ready", 32'(req_ready), 0);
      tick();
    end
    force_busy = 1'b0;
    upd_busy();
    #1;
    chk("busy release ready", 32'(req_ready), 4'b0010);
    run_frame(4'b0010, 1, 8'h42, 1'b0, "busy_rel");

    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("pre-rst busy", 32'(arb_busy), 1);
    chk("pre-rst data", 32'(tx_data), 8'h41);
    #2 reset = 1'b1;
    #1;
    chk("mid-rst start", 32'(tx_start), 0);
    chk("mid-rst data", 32'(tx_data), 0);
    chk("mid-rst arb_busy", 32'(arb_busy), 0);
    chk("mid-rst grant", 32'(grant_id), 0);
    busy_to = -2;
    upd_busy();
    tick();
    reset = 1'b0;
    run_frame(4'b1001, 0, 8'h41, 1'b0, "post_rst");

    // random traffic against a cycle-timeline model of grants, frames and aborts
    pend = '0;
    for (int i = 0; i < N; i++) pdata[i] = 8'h00;
    free_at = cyc; mptr = 0; es = -100; ed = cyc; ee = -100; eb = 8'h41; eg = 0;
    for (int r = 0; r < 500; r++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pdata[i] = 8'($urandom);
        end
      req_valid = pend;
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = pdata[i];
      #1;
      er = '0; xw = -1;
      if (cyc >= free_at && pend != '0 && !tx_busy) begin
        for (int k = 1; k <= N && xw < 0; k++)
          if (pend[(mptr + k) % N]) xw = (mptr + k) % N;
        er[xw] = 1'b1;
      end
      chk("rnd ready", 32'(req_ready), 32'(er));
      chk("rnd start", 32'(tx_start), 32'(cyc == es));
      chk("rnd done", 32'(done), 32'(cyc == ed));
      chk("rnd err", 32'(err_timeout), 32'(cyc == ee));
      chk("rnd arb_busy", 32'(arb_busy), 32'(cyc >= es && cyc < free_at));
      chk("rnd data", 32'(tx_data), 32'(eb));
      chk("rnd grant", 32'(grant_id), eg);
      if (xw >= 0) begin
        eb = pdata[xw]; eg = xw; mptr = xw; es = cyc + 1;
        uart_en  = $urandom_range(0, 3) != 0;
        busy_len = $urandom_range(1, 6);
        if (uart_en) begin
          ed = cyc + 4 + busy_len; ee = -100; free_at = ed;
        end else begin
          ee = cyc + 17; ed = -100; free_at = ee;
        end
      end
      tick();
      if (xw >= 0) pend[xw] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
